// File: rtl/sdram_request_arbiter.sv
// Two client ports plus a periodic auto-refresh timer arbitrated onto one SDRAM controller command port.
// Define SDRAM_ARB_FIXED_PRIORITY_EN for fixed port-0 priority; otherwise ports are served round-robin.
module sdram_request_arbiter #(
  parameter int CLOCK_SPEED_MHZ     = 0,
  parameter int REFRESH_INTERVAL_NS = 7800,
  parameter int MAX_OUTSTANDING     = 4,
  parameter int ADDR_WIDTH          = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ctrl_init_done,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic                  p0_wr,
  input  logic [15:0]           p0_wdata,
  input  logic [1:0]            p0_wmask,
  output logic                  p0_rdata_valid,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic                  p1_wr,
  input  logic [15:0]           p1_wdata,
  input  logic [1:0]            p1_wmask,
  output logic                  p1_rdata_valid,
  output logic [15:0]           rdata,
  output logic                  ctrl_cmd_valid,
  input  logic                  ctrl_cmd_ready,
  output logic [ADDR_WIDTH-1:0] ctrl_addr,
  output logic                  ctrl_wr,
  output logic [15:0]           ctrl_wdata,
  output logic [1:0]            ctrl_wmask,
  input  logic [15:0]           ctrl_rdata,
  input  logic                  ctrl_rdata_valid,
  output logic                  ctrl_refresh_req,
  input  logic                  ctrl_refresh_ack,
  output logic                  refresh_overrun
);

  localparam int REFRESH_CYCLES = (REFRESH_INTERVAL_NS * CLOCK_SPEED_MHZ) / 1000;
  localparam int CNT_W          = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES + 1) : 1;
  localparam int PTR_W          = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] RELOAD      = CNT_W'(REFRESH_CYCLES);
  localparam logic [PTR_W:0]   FIFO_DEPTH  = (PTR_W + 1)'(MAX_OUTSTANDING);
  localparam logic [3:0]       PENDING_MAX = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_REFRESH = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic                    cmd_valid_r, refresh_req_r, overrun_r;
  logic [CNT_W-1:0]        refresh_cnt_r;
  logic [3:0]              pending_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic                    wr_r, cmd_port_r;
  logic [15:0]             wdata_r, rdata_r;
  logic [1:0]              wmask_r;
  logic                    rv0_r, rv1_r;
  logic                    tag_mem_r [MAX_OUTSTANDING];
  logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]          fifo_cnt_r;
  logic                    fifo_full_s, push_s, pop_s, tag_head_s;
  logic                    elig0_s, elig1_s, grant_port_s, grant_s, can_issue_s;
  logic                    expire_s, refresh_done_s;

  // Expiry fires on the last count of an interval so the period is exactly REFRESH_CYCLES.
  assign expire_s       = ctrl_init_done & (refresh_cnt_r <= CNT_W'(1));
  assign refresh_done_s = (state_r == ST_REFRESH) & ctrl_refresh_ack;

  assign fifo_full_s = (fifo_cnt_r == FIFO_DEPTH);
  assign push_s      = (state_r == ST_CMD) & ctrl_cmd_ready & ~wr_r;
  assign pop_s       = ctrl_rdata_valid & (fifo_cnt_r != '0);
  assign tag_head_s  = tag_mem_r[rd_ptr_r];

  assign elig0_s     = p0_valid & (p0_wr | ~fifo_full_s);
  assign elig1_s     = p1_valid & (p1_wr | ~fifo_full_s);
  assign can_issue_s = (state_r == ST_IDLE) & ctrl_init_done & (pending_r == 4'd0) & ~reset;
  assign grant_s     = can_issue_s & (elig0_s | elig1_s);
  assign p0_ready    = grant_s & ~grant_port_s;
  assign p1_ready    = grant_s & grant_port_s;

  assign ctrl_cmd_valid   = cmd_valid_r;
  assign ctrl_refresh_req = refresh_req_r;
  assign refresh_overrun  = overrun_r;
  assign ctrl_addr        = addr_r;
  assign ctrl_wr          = wr_r;
  assign ctrl_wdata       = wdata_r;
  assign ctrl_wmask       = wmask_r;
  assign rdata            = rdata_r;
  assign p0_rdata_valid   = rv0_r;
  assign p1_rdata_valid   = rv1_r;

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
  // Port selection: port 0 always wins when eligible.
  always_comb begin
    grant_port_s = 1'b0;
    if (elig0_s) begin
      grant_port_s = 1'b0;
    end else begin
      grant_port_s = 1'b1;
    end
  end
`else
  logic last_grant_r;

  // Port selection: on contention serve the port that was not granted last.
  always_comb begin
    grant_port_s = 1'b0;
    if (elig0_s && elig1_s) begin
      grant_port_s = ~last_grant_r;
    end else if (elig1_s) begin
      grant_port_s = 1'b1;
    end else begin
      grant_port_s = 1'b0;
    end
  end

  // Round-robin history, starting so that port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= 1'b1;
    end else if (grant_s) begin
      last_grant_r <= grant_port_s;
    end
  end
`endif

  // Next-state logic; refresh takes priority over client traffic in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ctrl_init_done && (pending_r != 4'd0)) begin
          state_s = ST_REFRESH;
        end else if (grant_s) begin
          state_s = ST_CMD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (ctrl_cmd_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CMD;
        end
      end
      ST_REFRESH: begin
        if (ctrl_refresh_ack) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REFRESH;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register with registered handshake outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cmd_valid_r   <= 1'b0;
      refresh_req_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cmd_valid_r   <= (state_s == ST_CMD);
      refresh_req_r <= (state_s == ST_REFRESH);
    end
  end

  // Command fields captured from the winning port at grant and held through the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r     <= '0;
      wr_r       <= 1'b0;
      wdata_r    <= 16'h0000;
      wmask_r    <= 2'b00;
      cmd_port_r <= 1'b0;
    end else if (grant_s) begin
      addr_r     <= grant_port_s ? p1_addr  : p0_addr;
      wr_r       <= grant_port_s ? p1_wr    : p0_wr;
      wdata_r    <= grant_port_s ? p1_wdata : p0_wdata;
      wmask_r    <= grant_port_s ? p1_wmask : p0_wmask;
      cmd_port_r <= grant_port_s;
    end
  end

  // Refresh interval timer and saturating pending-refresh counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt_r <= RELOAD;
      pending_r     <= 4'd0;
      overrun_r     <= 1'b0;
    end else begin
      if (ctrl_init_done) begin
        refresh_cnt_r <= expire_s ? RELOAD : (refresh_cnt_r - CNT_W'(1));
      end
      if (expire_s && !refresh_done_s) begin
        if (pending_r == PENDING_MAX) begin
          overrun_r <= 1'b1;
        end else begin
          pending_r <= pending_r + 4'd1;
        end
      end else if (refresh_done_s && !expire_s) begin
        pending_r <= pending_r - 4'd1;
      end
    end
  end

  // Read-tag FIFO pointers and occupancy; a reset flushes all tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (push_s && !pop_s) begin
        fifo_cnt_r <= fifo_cnt_r + (PTR_W + 1)'(1);
      end else if (pop_s && !push_s) begin
        fifo_cnt_r <= fifo_cnt_r - (PTR_W + 1)'(1);
      end
    end
  end

  // Tag storage: the port id of each read accepted by the controller.
  always_ff @(posedge clk) begin
    if (push_s) begin
      tag_mem_r[wr_ptr_r] <= cmd_port_r;
    end
  end

  // Read return: data and per-port strobe registered one cycle after the controller strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r <= 16'h0000;
      rv0_r   <= 1'b0;
      rv1_r   <= 1'b0;
    end else begin
      rv0_r <= pop_s & ~tag_head_s;
      rv1_r <= pop_s & tag_head_s;
      if (pop_s) begin
        rdata_r <= ctrl_rdata;
      end
    end
  end

endmodule

// File: doc/sdram_request_arbiter.md
# sdram_request_arbiter
Front-end stage directly upstream of the SDRAM controller: arbitrates two client ports plus a periodic auto-refresh timer into the controller's single command interface. Routes in-order read data back to the issuing port. Holds off all traffic until the controller reports initialization complete.

## Interface
- CLOCK_SPEED_MHZ, 0: clk frequency; must be >0.
- REFRESH_INTERVAL_NS, 7800: tREFI; REFRESH_CYCLES = floor(REFRESH_INTERVAL_NS*CLOCK_SPEED_MHZ/1000), 780 at 100 MHz.
- MAX_OUTSTANDING, 4: read-tag FIFO depth (power of 2).
- ADDR_WIDTH, 25: word address width.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- ctrl_init_done  in  1  controller finished power-up init; level.
- pN_valid  in  1  port N (N=0,1) request valid; held until pN_ready.
- pN_ready  out  1  one-cycle accept strobe for port N.
- pN_addr  in  ADDR_WIDTH  port N word address.
- pN_wr  in  1  1 = write, 0 = read.
- pN_wdata  in  16  write data.
- pN_wmask  in  2  byte mask, 1 = byte masked (maps to DQM).
- pN_rdata_valid  out  1  read data for port N on rdata.
- rdata  out  16  registered read data, shared by both ports.
- ctrl_cmd_valid / ctrl_cmd_ready  out / in  1  command handshake to controller.
- ctrl_addr, ctrl_wr, ctrl_wdata, ctrl_wmask  out  ADDR_WIDTH, 1, 16, 2  registered command fields.
- ctrl_rdata / ctrl_rdata_valid  in  16 / 1  in-order read return from controller.
- ctrl_refresh_req  out  1  auto-refresh request, held until ack.
- ctrl_refresh_ack  in  1  one-cycle refresh accept.
- refresh_overrun  out  1  sticky: pending refreshes saturated.

## Operation
- States: IDLE, CMD, REFRESH. Reset → IDLE; all outputs 0; tag FIFO empty; pending=0; counter=REFRESH_CYCLES; last_grant=1.
- Refresh timer: frozen while ctrl_init_done=0. Otherwise decrements each cycle; at 0 reloads REFRESH_CYCLES and increments pending (4-bit, saturates at 8). Increment attempted while pending=8 sets refresh_overrun (cleared only by reset).
- IDLE, ctrl_init_done=1, priority: pending>0 → REFRESH; else a port grant → CMD.
- Port eligibility: pN_valid and (pN_wr or tag FIFO not full).
- Round-robin: both eligible → grant port ≠ last_grant; last_grant updates on each port grant.
- Grant in cycle T: pN_ready=1 during T (combinational from IDLE + arbitration); ctrl_* fields load at edge T; state CMD.
- CMD: ctrl_cmd_valid=1, fields stable, until ctrl_cmd_ready=1; on that edge → IDLE; read pushes port id into tag FIFO.
- REFRESH: ctrl_refresh_req=1 until ctrl_refresh_ack; on that edge pending decrements (timer expiry same cycle: net unchanged) → IDLE.
- ctrl_rdata_valid pops FIFO head; push and pop in the same cycle allowed with no count change. Pop on empty FIFO: data dropped, no strobe.

## Timing
- Minimum 2 cycles per client command (grant cycle + CMD handshake cycle).
- Read return: rdata and pN_rdata_valid registered, 1 cycle after ctrl_rdata_valid; strobe width 1 cycle.
- First refresh request: REFRESH_CYCLES+1 cycles after ctrl_init_done rises (if IDLE).
- Refresh pending while in CMD waits for command completion; never preempts a handshake.
- Reset mid-CMD/REFRESH: request dropped, valids/strobes low next cycle, FIFO flushed.

## Configuration
- SDRAM_ARB_FIXED_PRIORITY_EN defined: port 0 always wins over port 1; last_grant unused. Undefined: round-robin as above.

## Test plan
- CLOCK_SPEED_MHZ=100, init_done at cycle 10, no traffic → ctrl_refresh_req rises at cycle 791; ack there → next request at 1571.
- Both ports read continuously, ready=1 → grants alternate p0,p1,p0 starting p0; with FIXED_PRIORITY_EN only p0.
- 4 reads outstanding, no return → read requests stall, a p1 write still granted; one ctrl_rdata_valid → next read granted.
- Reads p0 then p1; controller returns 0xA5A5, 0x5A5A → p0_rdata_valid with 0xA5A5, then p1_rdata_valid with 0x5A5A, each 1 cycle late.
- refresh_ack withheld 9 intervals → pending saturates at 8, refresh_overrun=1 and stays until reset.
- Reset asserted while ctrl_cmd_valid=1 and FIFO count 2 → outputs 0, FIFO empty, later ctrl_rdata_valid produces no pN strobe.
